// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains an FWFT FIFO into a framed AXI4-Stream master through a 2-entry skid buffer.
module fifo_axis_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_W      = 8,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [LEN_W-1:0]      pkt_len,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,
    output logic [CNT_W-1:0]      pkt_count,
    output logic                  busy
);
    logic [DATA_WIDTH-1:0] r_out_data, r_skid_data;
    logic                  r_out_valid, r_out_last, r_skid_valid, r_skid_last;
    logic [LEN_W-1:0]      r_beat_cnt, r_len_q;
    logic [CNT_W-1:0]      r_pkt_count;
    logic [LEN_W-1:0]      w_len1, w_eff_len;
    logic                  w_pop, w_hs, w_load_out, w_last;

    assign w_pop      = en & ~fifo_empty & ~r_skid_valid;
    assign w_hs       = r_out_valid & m_axis_tready;
    assign w_load_out = ~r_out_valid | m_axis_tready;
    assign w_len1     = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
    // Length is latched at the first pop of a packet; later pkt_len changes wait for the next one.
    assign w_eff_len  = (r_beat_cnt == '0) ? w_len1 : r_len_q;
    assign w_last     = r_beat_cnt == w_eff_len - LEN_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_last  <= 1'b0;
            r_beat_cnt   <= '0;
            r_len_q      <= '0;
            r_pkt_count  <= '0;
        end else begin
            if (w_load_out) begin
                r_out_valid <= r_skid_valid | w_pop;
                if (r_skid_valid) begin
                    r_out_data <= r_skid_data;
                    r_out_last <= r_skid_last;
                end else if (w_pop) begin
                    r_out_data <= fifo_dout;
                    r_out_last <= w_last;
                end
            end
            if (w_pop && !w_load_out) begin
                r_skid_valid <= 1'b1;
                r_skid_data  <= fifo_dout;
                r_skid_last  <= w_last;
            end else if (w_load_out) begin
                r_skid_valid <= 1'b0;
            end
            if (w_pop) begin
                if (r_beat_cnt == '0) r_len_q <= w_len1;
                r_beat_cnt <= w_last ? '0 : r_beat_cnt + LEN_W'(1);
            end
            if (w_hs && r_out_last) r_pkt_count <= r_pkt_count + CNT_W'(1);
        end
    end

    assign fifo_rd_en    = w_pop;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tlast  = r_out_last;
    assign pkt_count     = r_pkt_count;
    assign busy          = (r_beat_cnt != '0) | r_out_valid | r_skid_valid;
endmodule

// File: tb/tb_fifo_axis_reader.sv
// tb_fifo_axis_reader: directed bench for fifo_axis_reader with a behavioural FWFT FIFO.
module tb_fifo_axis_reader;
    logic        clk = 0, rst_n = 0, en = 0, tready = 0;
    logic [7:0]  pkt_len = 0;
    logic        fifo_empty, fifo_rd_en, tvalid, tlast, busy;
    logic [31:0] fifo_dout, tdata, pkt_count;
    logic [31:0] mem [0:63];
    logic [5:0]  wp = 0, rp = 0;
    int          npass = 0, nfail = 0, ntot = 0, cyc = 0, stall_err = 0, pop_err = 0, base = 0;
    logic [31:0] ld[$];
    logic        lt[$];
    int          lc[$];
    logic        pv = 0, pr = 0, pl = 0;
    logic [31:0] pd = 0;

    fifo_axis_reader dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pkt_len(pkt_len),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tlast(tlast),
        .m_axis_tready(tready), .pkt_count(pkt_count), .busy(busy)
    );

    always #5 clk = ~clk;
    assign fifo_empty = wp == rp;
    assign fifo_dout  = mem[rp];
    always @(posedge clk) if (fifo_rd_en) rp <= rp + 6'd1;

    // Handshakes are logged on the falling edge ahead of the edge that completes them.
    always @(negedge clk) begin
        cyc++;
        if (rst_n && pv && !pr && !(tvalid && tdata === pd && tlast === pl)) stall_err++;
        if (fifo_rd_en && (fifo_empty || dut.r_skid_valid)) pop_err++;
        if (tvalid && tready) begin
            ld.push_back(tdata);
            lt.push_back(tlast);
            lc.push_back(cyc);
        end
        pv = tvalid; pr = tready; pd = tdata; pl = tlast;
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(logic [31:0] d);
        mem[wp] = d;
        wp = wp + 6'd1;
    endtask

    task automatic wait_beats(string tag, int n);
        int k = 0;
        while (ld.size() < n && k < 200) begin
            step(1);
            k++;
        end
        chk(tag, ld.size(), n);
    endtask

    task automatic beat(string tag, int i, logic [31:0] d, logic l);
        chk({tag, "_data"}, (i < ld.size()) ? ld[i] : 32'hDEAD, d);
        chk({tag, "_last"}, (i < ld.size()) ? 32'(lt[i]) : 32'hDEAD, 32'(l));
    endtask

    initial begin
        step(2);
        chk("rst_tvalid", 32'(tvalid), 0);
        chk("rst_tlast", 32'(tlast), 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1;
        step(1);

        pkt_len = 4; tready = 1;
        for (int i = 0; i < 8; i++) push(32'h10 + i);
        en = 1;
        wait_beats("t1_count", 8);
        for (int i = 0; i < 8; i++) beat("t1", i, 32'h10 + i, i == 3 || i == 7);
        chk("t1_back_to_back", lc[7] - lc[0], 7);
        step(2);
        chk("t1_pkt_count", pkt_count, 2);
        chk("t1_busy", 32'(busy), 0);

        base = ld.size();
        pkt_len = 3;
        for (int i = 0; i < 6; i++) push(32'h20 + i);
        for (int k = 0; k < 60 && ld.size() < base + 6; k++) begin
            tready = (k % 3 == 0);
            step(1);
        end
        tready = 1;
        chk("t2_count", ld.size(), base + 6);
        for (int i = 0; i < 6; i++) beat("t2", base + i, 32'h20 + i, i == 2 || i == 5);
        step(2);
        chk("t2_pkt_count", pkt_count, 4);
        chk("t2_busy", 32'(busy), 0);

        base = ld.size();
        pkt_len = 0;
        for (int i = 0; i < 3; i++) push(32'h30 + i);
        wait_beats("t3_count", base + 3);
        for (int i = 0; i < 3; i++) beat("t3", base + i, 32'h30 + i, 1'b1);
        step(2);
        chk("t3_pkt_count", pkt_count, 7);

        base = ld.size();
        pkt_len = 5;
        push(32'h40); push(32'h41);
        wait_beats("t4_first", base + 2);
        step(1);
        chk("t4_busy_open", 32'(busy), 1);
        pkt_len = 2;
        for (int i = 2; i < 7; i++) push(32'h40 + i);
        wait_beats("t4_count", base + 7);
        for (int i = 0; i < 7; i++) beat("t4", base + i, 32'h40 + i, i == 4 || i == 6);
        step(2);
        chk("t4_pkt_count", pkt_count, 9);

        base = ld.size();
        en = 0; pkt_len = 4;
        for (int i = 0; i < 8; i++) push(32'h50 + i);
        en = 1;
        step(2);
        en = 0;
        step(4);
        chk("t5_drained", ld.size(), base + 2);
        chk("t5_no_pop", 32'(fifo_rd_en), 0);
        chk("t5_fifo_left", 32'(wp - rp), 6);
        chk("t5_busy", 32'(busy), 1);
        chk("t5_tvalid", 32'(tvalid), 0);
        chk("t5_pkt_hold", pkt_count, 9);
        en = 1;
        wait_beats("t5_count", base + 8);
        for (int i = 0; i < 8; i++) beat("t5", base + i, 32'h50 + i, i == 3 || i == 7);
        step(2);
        chk("t5_pkt_count", pkt_count, 11);

        tready = 0; pkt_len = 4;
        for (int i = 0; i < 5; i++) push(32'h60 + i);
        en = 1;
        step(3);
        chk("t6_out_full", 32'(tvalid), 1);
        chk("t6_skid_full", 32'(dut.r_skid_valid), 1);
        en = 0;
        #2 rst_n = 0;
        #1;
        chk("t6_rst_tvalid", 32'(tvalid), 0);
        chk("t6_rst_pkt_count", pkt_count, 0);
        chk("t6_rst_beat_cnt", 32'(dut.r_beat_cnt), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        step(2);
        rst_n = 1;
        base = ld.size();
        pkt_len = 3; tready = 1; en = 1;
        wait_beats("t6_count", base + 3);
        for (int i = 0; i < 3; i++) beat("t6", base + i, 32'h62 + i, i == 2);
        step(2);
        chk("t6_pkt_count", pkt_count, 1);
        chk("t6_busy", 32'(busy), 0);

        chk("stall_stable", stall_err, 0);
        chk("pop_rule", pop_err, 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
